// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: next-PC selection for the RISC-V fetch stage.
// Sources in priority order: trap, stall, mret, jalr, branch/JAL, RAS return, sequential.
// Redirects to a target that is not 4-byte aligned are turned into a trap.
module pc_fetch_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 'h100,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_offset,
  input  logic            jalr_valid,
  input  logic [XLEN-1:0] jalr_target,
  input  logic            call,
  input  logic            ret_pred,
  input  logic            trap,
  input  logic            mret,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] epc_out,
  output logic            misaligned,
  output logic            ras_empty,
  output logic            ras_full
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_TRAP,
    SRC_STALL,
    SRC_MRET,
    SRC_JALR,
    SRC_BR,
    SRC_RET
  } src_e;

  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]   ras_ptr;    // next write slot; top of stack is ras_ptr-1
  logic [CW-1:0]   ras_count;
  logic [PW-1:0]   ras_top_idx;

  src_e            src;
  logic [XLEN-1:0] target;
  logic            misalign_hit;
  logic            push_en;
  logic            pop_en;

  assign pc_plus4    = pc_out + XLEN'(4);
  assign ras_top_idx = ras_ptr - PW'(1);
  assign ras_empty   = (ras_count == '0);
  assign ras_full    = (ras_count == CW'(RAS_DEPTH));

  // Pick the winning source and its target address.
  always_comb begin
    src    = SRC_SEQ;
    target = pc_plus4;
    if (trap) begin
      src = SRC_TRAP;
    end else if (stall) begin
      src = SRC_STALL;
    end else if (mret) begin
      src    = SRC_MRET;
      target = epc_out;
    end else if (jalr_valid) begin
      src    = SRC_JALR;
      target = jalr_target & ~XLEN'(1);
    end else if (br_taken) begin
      src    = SRC_BR;
      target = pc_out + br_offset;
    end else if (ret_pred && !ras_empty) begin
      src    = SRC_RET;
      target = ras_mem[ras_top_idx];
    end
  end

  // Misalignment check and RAS update enables; only the winner may touch the RAS.
  always_comb begin
    misalign_hit = (src inside {SRC_MRET, SRC_JALR, SRC_BR, SRC_RET}) && (target[1:0] != 2'b00);
    push_en      = call && (src inside {SRC_JALR, SRC_BR}) && !misalign_hit;
    pop_en       = (src == SRC_RET) && !misalign_hit;
  end

  // PC, EPC, misaligned pulse and RAS pointer/count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_out     <= RESET_VECTOR;
      epc_out    <= '0;
      misaligned <= 1'b0;
      ras_ptr    <= '0;
      ras_count  <= '0;
    end else begin
      misaligned <= 1'b0;
      if (src == SRC_TRAP || misalign_hit) begin
        pc_out     <= TRAP_VECTOR;
        epc_out    <= pc_out;
        misaligned <= misalign_hit;
      end else if (src != SRC_STALL) begin
        pc_out <= target;
      end
      // A full push overwrites the oldest slot, which is the one at ras_ptr.
      if (push_en) begin
        ras_ptr <= ras_ptr + PW'(1);
        if (!ras_full) ras_count <= ras_count + CW'(1);
      end else if (pop_en) begin
        ras_ptr   <= ras_top_idx;
        ras_count <= ras_count - CW'(1);
      end
    end
  end

  // RAS storage; contents need no reset since the count gates every read.
  always_ff @(posedge clk) begin
    if (push_en && !reset) ras_mem[ras_ptr] <= pc_plus4;
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: scoreboard bench with a queue-based reference model of the fetch PC.
module tb_pc_fetch_unit;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RV    = 32'h0;
  localparam logic [31:0] TV    = 32'h100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0, br_taken = 1'b0, jalr_valid = 1'b0, call = 1'b0;
  logic        ret_pred = 1'b0, trap = 1'b0, mret = 1'b0;
  logic [31:0] br_offset = '0, jalr_target = '0;
  logic [31:0] pc_out, pc_plus4, epc_out;
  logic        misaligned, ras_empty, ras_full;

  pc_fetch_unit #(.XLEN(32), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken), .br_offset(br_offset),
    .jalr_valid(jalr_valid), .jalr_target(jalr_target), .call(call), .ret_pred(ret_pred),
    .trap(trap), .mret(mret), .pc_out(pc_out), .pc_plus4(pc_plus4), .epc_out(epc_out),
    .misaligned(misaligned), .ras_empty(ras_empty), .ras_full(ras_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
    logic        mis;
    logic        empty;
    logic        full;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  // Reference model state
  logic [31:0] m_pc  = RV;
  logic [31:0] m_epc = '0;
  logic        m_mis = 1'b0;
  logic [31:0] m_ras[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Start a cycle: wait for the inactive edge and drop all requests.
  task automatic begin_cyc();
    @(negedge clk);
    reset = 1'b0; stall = 1'b0; br_taken = 1'b0; jalr_valid = 1'b0; call = 1'b0;
    ret_pred = 1'b0; trap = 1'b0; mret = 1'b0; br_offset = '0; jalr_target = '0;
  endtask

  // Finish a cycle: apply the architectural rules to the model and queue the outcome.
  task automatic end_cyc();
    logic [31:0] t;
    logic        redirect, do_pop, do_push;
    exp_t        e;
    redirect = 1'b1; do_pop = 1'b0; do_push = 1'b0;
    m_mis = 1'b0;
    if (reset) begin
      m_pc = RV; m_epc = '0; m_ras.delete();
    end else if (trap) begin
      m_epc = m_pc; m_pc = TV;
    end else if (!stall) begin
      if (mret) t = m_epc;
      else if (jalr_valid) begin t = {jalr_target[31:1], 1'b0}; do_push = call; end
      else if (br_taken) begin t = m_pc + br_offset; do_push = call; end
      else if (ret_pred && m_ras.size() > 0) begin t = m_ras[m_ras.size()-1]; do_pop = 1'b1; end
      else begin t = m_pc + 32'd4; redirect = 1'b0; end
      if (redirect && (t % 4 != 0)) begin
        m_epc = m_pc; m_pc = TV; m_mis = 1'b1;
      end else begin
        if (do_push) begin
          if (m_ras.size() == DEPTH) void'(m_ras.pop_front());
          m_ras.push_back(m_pc + 32'd4);
        end
        if (do_pop) void'(m_ras.pop_back());
        m_pc = t;
      end
    end
    e.pc = m_pc; e.epc = m_epc; e.mis = m_mis;
    e.empty = (m_ras.size() == 0); e.full = (m_ras.size() == DEPTH);
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin begin_cyc(); end_cyc(); end
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) begin begin_cyc(); reset = 1'b1; end_cyc(); end
  endtask

  // Direct check of a known value just after the next active edge.
  task automatic chk_after(input string name, input logic [31:0] req);
    @(posedge clk); #1;
    chk(name, pc_out, req);
  endtask

  // Monitor: one expected entry per clock, compared after the edge settles.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pc_out", pc_out, e.pc);
        chk("pc_plus4", pc_plus4, e.pc + 32'd4);
        chk("epc_out", epc_out, e.epc);
        chk("misaligned", {31'b0, misaligned}, {31'b0, e.mis});
        chk("ras_empty", {31'b0, ras_empty}, {31'b0, e.empty});
        chk("ras_full", {31'b0, ras_full}, {31'b0, e.full});
      end
    end
  end

  initial begin
    int wait_cyc;
    // T1: reset then idle counting
    do_reset();
    chk("t1_reset_empty", {31'b0, ras_empty}, 32'd1);
    begin_cyc(); end_cyc(); chk_after("t1_pc4", 32'h4);
    begin_cyc(); end_cyc(); chk_after("t1_pc8", 32'h8);
    begin_cyc(); end_cyc(); chk_after("t1_pcC", 32'hC);
    // T2: call via branch, then predicted return
    begin_cyc(); end_cyc();                               // pc 0x10
    begin_cyc(); br_taken = 1'b1; br_offset = -32'sd8; call = 1'b1; end_cyc();
    chk_after("t2_branch", 32'h8);
    begin_cyc(); ret_pred = 1'b1; end_cyc(); chk_after("t2_ret", 32'h14);
    chk("t2_ras_empty", {31'b0, ras_empty}, 32'd1);
    // T3: overflow the RAS with five calls, then five returns
    do_reset();
    for (int i = 0; i < 5; i++) begin
      begin_cyc(); br_taken = 1'b1; br_offset = 32'd4; call = 1'b1; end_cyc();
    end
    for (int i = 0; i < 5; i++) begin begin_cyc(); ret_pred = 1'b1; end_cyc(); end
    // T4: stall blocks jalr, trap overrides stall, mret returns
    do_reset();
    idle(8);                                              // pc 0x20
    begin_cyc(); stall = 1'b1; jalr_valid = 1'b1; jalr_target = 32'h40; end_cyc();
    chk_after("t4_stall", 32'h20);
    begin_cyc(); stall = 1'b1; trap = 1'b1; end_cyc(); chk_after("t4_trap", 32'h100);
    chk("t4_epc", epc_out, 32'h20);
    begin_cyc(); mret = 1'b1; end_cyc(); chk_after("t4_mret", 32'h20);
    // T5: misaligned jalr
    begin_cyc(); jalr_valid = 1'b1; jalr_target = 32'h42; call = 1'b1; end_cyc();
    chk_after("t5_trap_pc", 32'h100);
    chk("t5_mis_pulse", {31'b0, misaligned}, 32'd1);
    begin_cyc(); end_cyc(); chk_after("t5_after", 32'h104);
    chk("t5_mis_clear", {31'b0, misaligned}, 32'd0);
    // T6: wrap, trap priority, reset during branch
    begin_cyc(); jalr_valid = 1'b1; jalr_target = 32'hFFFF_FFFC; end_cyc();
    begin_cyc(); end_cyc(); chk_after("t6_wrap", 32'h0);
    begin_cyc(); trap = 1'b1; jalr_valid = 1'b1; jalr_target = 32'h80;
    br_taken = 1'b1; br_offset = 32'h40; end_cyc();
    chk_after("t6_trap_wins", 32'h100);
    begin_cyc(); reset = 1'b1; br_taken = 1'b1; br_offset = 32'h40; end_cyc();
    chk_after("t6_reset_wins", 32'h0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      begin_cyc();
      reset       = ($urandom_range(0, 199) == 0);
      trap        = ($urandom_range(0, 19) == 0);
      stall       = ($urandom_range(0, 7) == 0);
      mret        = ($urandom_range(0, 15) == 0);
      jalr_valid  = ($urandom_range(0, 7) == 0);
      jalr_target = ($urandom() & 32'hFFFF_FFFC) | (($urandom_range(0, 5) == 0) ? 32'h2 : 32'h0)
                    | 32'($urandom_range(0, 1));
      br_taken    = ($urandom_range(0, 5) == 0);
      br_offset   = 32'($signed($urandom_range(0, 255)) - 128) & (($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      call        = ($urandom_range(0, 1) == 1);
      ret_pred    = ($urandom_range(0, 3) == 0);
      end_cyc();
    end

    begin_cyc();
    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 20) begin @(posedge clk); wait_cyc++; end
    #3;
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
